// File: rtl/plc_output_pkg.sv
// Shared types and defaults for the PLC output path (register stage and
// shift driver).
package plc_output_pkg;

  localparam int unsigned OUT_WIDTH_DEF   = 16;
  localparam int unsigned OUT_CLK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } drv_state_t;

endpackage

// File: rtl/output_phase_timer.sv
// Loadable down-counter timing one SRCLK/RCLK phase of the shift driver.
// terminal is high in the last of the CLK_DIV cycles following a load.
module output_phase_timer #(
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned CW = $clog2(CLK_DIV + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic terminal
);

  logic [CW-1:0] count;

  // reload on phase entry, count down to zero and park there
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(CLK_DIV);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign terminal = (count == CW'(1));

endmodule

// File: rtl/output_shift_driver.sv
// Serialises the latched output image into a 74HC595-style shift/latch
// chain. All chain-facing outputs are registered.
// Optional macro OUTPUT_WATCHDOG_EN adds a sticky no-start watchdog that
// forces the chain outputs off.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | waiting for start, chain outputs idle
// ST_SETUP    | SRCLK low, SER presents the current bit
// ST_SHIFT_HI | SRCLK high, SER held; bit shifted on exit
// ST_LATCH    | RCLK high to transfer the chain to its outputs
module output_shift_driver
  import plc_output_pkg::*;
#(
  parameter int unsigned WIDTH      = OUT_WIDTH_DEF,
  parameter int unsigned CLK_DIV    = OUT_CLK_DIV_DEF,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned WDT_CYCLES = 100000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] OUTPUTDRIVER_DATA,
  input  logic             OUTPUTDRIVER_START,
  output logic             OUTPUTDRIVER_BUSY,
  output logic             OUTPUTDRIVER_DONE,
  output logic             OUTPUTDRIVER_SER,
  output logic             OUTPUTDRIVER_SRCLK,
  output logic             OUTPUTDRIVER_RCLK,
  output logic             OUTPUTDRIVER_OE_N,
  output logic             OUTPUTDRIVER_WDT_FAULT
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  drv_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             oe_n_q, oe_n_d;
  logic             phase_load;
  logic             phase_tc;
  logic             wdt_trip;

  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  output_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (phase_load),
    .terminal(phase_tc)
  );

  // next-state and next-output decode; every output is computed here and
  // registered below so nothing reaches the pins combinationally
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bcnt_d     = bcnt_q;
    ser_d      = ser_q;
    srclk_d    = srclk_q;
    rclk_d     = rclk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    oe_n_d     = oe_n_q;
    phase_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (OUTPUTDRIVER_START) begin
          sreg_d     = OUTPUTDRIVER_DATA;
          bcnt_d     = BCW'(WIDTH);
          ser_d      = lead_bit(OUTPUTDRIVER_DATA);
          srclk_d    = 1'b0;
          busy_d     = 1'b1;
          phase_load = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_tc) begin
          srclk_d    = 1'b1;
          phase_load = 1'b1;
          state_d    = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_tc) begin
          srclk_d    = 1'b0;
          phase_load = 1'b1;
          sreg_d     = shift_out(sreg_q);
          bcnt_d     = bcnt_q - BCW'(1);
          if (bcnt_q == BCW'(1)) begin
            ser_d   = 1'b0;
            rclk_d  = 1'b1;
            state_d = ST_LATCH;
          end else begin
            ser_d   = lead_bit(sreg_d);
            state_d = ST_SETUP;
          end
        end
      end
      ST_LATCH: begin
        if (phase_tc) begin
          rclk_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          oe_n_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a watchdog fault keeps the physical outputs disabled regardless
    if (wdt_trip) oe_n_d = 1'b1;
  end

  // state and output registers; reset aborts any transfer without a latch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oe_n_q  <= oe_n_d;
    end
  end

`ifdef OUTPUT_WATCHDOG_EN
  localparam int unsigned WCW = $clog2(WDT_CYCLES + 1);

  logic [WCW-1:0] wdt_cnt_q;
  logic           wdt_fault_q;

  assign wdt_trip = wdt_fault_q || (wdt_cnt_q == WCW'(WDT_CYCLES));

  // idle-time counter; an accepted start shows the scan loop is alive
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdt_cnt_q   <= '0;
      wdt_fault_q <= 1'b0;
    end else begin
      wdt_fault_q <= wdt_trip;
      if (state_q == ST_IDLE && OUTPUTDRIVER_START) begin
        wdt_cnt_q <= '0;
      end else if (wdt_cnt_q != WCW'(WDT_CYCLES)) begin
        wdt_cnt_q <= wdt_cnt_q + WCW'(1);
      end
    end
  end

  assign OUTPUTDRIVER_WDT_FAULT = wdt_fault_q;
`else
  logic unused_wdt_cycles;

  assign unused_wdt_cycles      = ^WDT_CYCLES;
  assign wdt_trip               = 1'b0;
  assign OUTPUTDRIVER_WDT_FAULT = 1'b0;
`endif

  assign OUTPUTDRIVER_BUSY  = busy_q;
  assign OUTPUTDRIVER_DONE  = done_q;
  assign OUTPUTDRIVER_SER   = ser_q;
  assign OUTPUTDRIVER_SRCLK = srclk_q;
  assign OUTPUTDRIVER_RCLK  = rclk_q;
  assign OUTPUTDRIVER_OE_N  = oe_n_q;

endmodule

// File: tb/tb_output_shift_driver.sv
// Scoreboard bench for output_shift_driver. Instance 0 uses defaults,
// instance 1 is LSB-first with CLK_DIV=1 and a short watchdog.
module tb_output_shift_driver;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [15:0] data  [2];
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic        ser   [2];
  logic        srclk [2];
  logic        rclk  [2];
  logic        oe_n  [2];
  logic        wdt   [2];

  output_shift_driver u_dut0 (
    .CLK                   (CLK),
    .RST                   (RST),
    .OUTPUTDRIVER_DATA     (data[0]),
    .OUTPUTDRIVER_START    (start[0]),
    .OUTPUTDRIVER_BUSY     (busy[0]),
    .OUTPUTDRIVER_DONE     (done[0]),
    .OUTPUTDRIVER_SER      (ser[0]),
    .OUTPUTDRIVER_SRCLK    (srclk[0]),
    .OUTPUTDRIVER_RCLK     (rclk[0]),
    .OUTPUTDRIVER_OE_N     (oe_n[0]),
    .OUTPUTDRIVER_WDT_FAULT(wdt[0])
  );

  output_shift_driver #(
    .CLK_DIV   (1),
    .MSB_FIRST (1'b0),
    .WDT_CYCLES(1000)
  ) u_dut1 (
    .CLK                   (CLK),
    .RST                   (RST),
    .OUTPUTDRIVER_DATA     (data[1]),
    .OUTPUTDRIVER_START    (start[1]),
    .OUTPUTDRIVER_BUSY     (busy[1]),
    .OUTPUTDRIVER_DONE     (done[1]),
    .OUTPUTDRIVER_SER      (ser[1]),
    .OUTPUTDRIVER_SRCLK    (srclk[1]),
    .OUTPUTDRIVER_RCLK     (rclk[1]),
    .OUTPUTDRIVER_OE_N     (oe_n[1]),
    .OUTPUTDRIVER_WDT_FAULT(wdt[1])
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned edge_cnt = 0;

  bit          q_bit  [2][$];
  int unsigned q_rclk [2][$];
  int unsigned q_done [2][$];

  logic        srclk_p [2];
  logic        rclk_p  [2];
  int unsigned rclk_rise_t [2];
  int unsigned div_of [2];

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_unexpected(input string name, input int i);
    n_checks++;
    n_err++;
    $display("FAIL %s on dut%0d: event with no expectation queued (t=%0t)", name, i, $time);
  endtask

  // monitor: pops expectations whenever a DUT shows a shift, latch or done
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (srclk[i] === 1'b1 && srclk_p[i] === 1'b0) begin
        if (q_bit[i].size() == 0) flag_unexpected("srclk_rise", i);
        else check($sformatf("ser_bit_dut%0d", i), 32'(ser[i]), 32'(q_bit[i].pop_front()));
      end
      if (rclk[i] === 1'b1 && rclk_p[i] === 1'b0) begin
        rclk_rise_t[i] = edge_cnt;
        if (q_rclk[i].size() == 0) flag_unexpected("rclk_rise", i);
        else check($sformatf("rclk_rise_cycle_dut%0d", i), edge_cnt, q_rclk[i].pop_front());
      end
      if (rclk[i] === 1'b0 && rclk_p[i] === 1'b1)
        check($sformatf("rclk_high_len_dut%0d", i), edge_cnt - rclk_rise_t[i], div_of[i]);
      if (done[i] === 1'b1) begin
        if (q_done[i].size() == 0) flag_unexpected("done", i);
        else check($sformatf("done_cycle_dut%0d", i), edge_cnt, q_done[i].pop_front());
      end
      srclk_p[i] = srclk[i];
      rclk_p[i]  = rclk[i];
    end
  end

  task automatic wait_until(input int unsigned t);
    while (edge_cnt < t) @(negedge CLK);
  endtask

  // drive a one-cycle start; c0 is cycle 0 (the cycle start is high)
  task automatic issue(input int i, input logic [15:0] d, output int unsigned c0);
    @(negedge CLK);
    data[i]  = d;
    start[i] = 1'b1;
    c0       = edge_cnt;
    @(negedge CLK);
    start[i] = 1'b0;
  endtask

  // stream: first shifted bit at [15]; rclk/done given as absolute cycles
  task automatic push_xfer(input int i, input logic [15:0] stream,
                           input int unsigned t_rclk, input int unsigned t_done);
    for (int k = 15; k >= 0; k--) q_bit[i].push_back(stream[k]);
    q_rclk[i].push_back(t_rclk);
    q_done[i].push_back(t_done);
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check($sformatf("%s_ser%0d", tag, i),   32'(ser[i]),   32'd0);
    check($sformatf("%s_srclk%0d", tag, i), 32'(srclk[i]), 32'd0);
    check($sformatf("%s_rclk%0d", tag, i),  32'(rclk[i]),  32'd0);
    check($sformatf("%s_oe_n%0d", tag, i),  32'(oe_n[i]),  32'd1);
    check($sformatf("%s_busy%0d", tag, i),  32'(busy[i]),  32'd0);
    check($sformatf("%s_done%0d", tag, i),  32'(done[i]),  32'd0);
    check($sformatf("%s_wdt%0d", tag, i),   32'(wdt[i]),   32'd0);
  endtask

  task automatic check_drained(input int i, input string tag);
    check($sformatf("%s_bits_left%0d", tag, i), q_bit[i].size(), 32'd0);
    check($sformatf("%s_done_left%0d", tag, i), q_done[i].size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c0, c1;
    div_of[0] = 4;
    div_of[1] = 1;
    for (int i = 0; i < 2; i++) begin
      data[i]    = 16'h0000;
      start[i]   = 1'b0;
      srclk_p[i] = 1'b0;
      rclk_p[i]  = 1'b0;
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // reset asserted while idle
    RST = 1'b1;
    #1;
    check_reset_vals(0, "idle_rst");
    check_reset_vals(1, "idle_rst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // A5C3 MSB first, with an ignored FFFF start at cycle 50
    issue(0, 16'hA5C3, c0);
    push_xfer(0, 16'b1010_0101_1100_0011, c0 + 129, c0 + 133);
    check("busy_cycle1", 32'(busy[0]), 32'd1);
    wait_until(c0 + 50);
    check("busy_cycle50", 32'(busy[0]), 32'd1);
    data[0]  = 16'hFFFF;
    start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    wait_until(c0 + 132);
    check("oe_n_before_done", 32'(oe_n[0]), 32'd1);
    check("busy_before_done", 32'(busy[0]), 32'd1);
    wait_until(c0 + 133);
    check("done_at_133", 32'(done[0]), 32'd1);
    check("oe_n_at_133", 32'(oe_n[0]), 32'd0);
    check("busy_at_133", 32'(busy[0]), 32'd0);
    wait_until(c0 + 140);
    check("oe_n_stays_low", 32'(oe_n[0]), 32'd0);
    check_drained(0, "a5c3");

    // reset at cycle 60 aborts the transfer; 7 bits already shifted
    issue(0, 16'h1234, c1);
    push_xfer(0, 16'b0001_0010_0011_0100, c1 + 129, c1 + 133);
    wait_until(c1 + 60);
    RST = 1'b1;
    #1;
    check_reset_vals(0, "abort_rst");
    check("abort_bits_left", q_bit[0].size(), 32'd9);
    q_bit[0].delete();
    q_rclk[0].delete();
    q_done[0].delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (150) @(negedge CLK);
    check("abort_oe_n", 32'(oe_n[0]), 32'd1);

    issue(0, 16'h00FF, c0);
    push_xfer(0, 16'b0000_0000_1111_1111, c0 + 129, c0 + 133);
    wait_until(c0 + 132);
    check("restart_oe_n_before", 32'(oe_n[0]), 32'd1);
    wait_until(c0 + 133);
    check("restart_done_133", 32'(done[0]), 32'd1);
    check("restart_oe_n_after", 32'(oe_n[0]), 32'd0);
    wait_until(c0 + 136);
    check_drained(0, "00ff");

    // LSB first, CLK_DIV=1, back-to-back start in the done cycle
    issue(1, 16'h0001, c0);
    push_xfer(1, 16'b1000_0000_0000_0000, c0 + 33, c0 + 34);
    wait_until(c0 + 33);
    check("lsb_busy_before_done", 32'(busy[1]), 32'd1);
    wait_until(c0 + 34);
    check("lsb_done_34", 32'(done[1]), 32'd1);
    check("lsb_busy_in_done", 32'(busy[1]), 32'd0);
    data[1]  = 16'h8000;
    start[1] = 1'b1;
    push_xfer(1, 16'b0000_0000_0000_0001, c0 + 34 + 33, c0 + 34 + 34);
    @(negedge CLK);
    start[1] = 1'b0;
    check("b2b_busy_next", 32'(busy[1]), 32'd1);
    wait_until(c0 + 34 + 36);
    check("b2b_oe_n", 32'(oe_n[1]), 32'd0);
    check_drained(1, "lsb");

`ifdef OUTPUT_WATCHDOG_EN
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    c0 = edge_cnt;
    wait_until(c0 + 990);
    check("wdt_before_timeout", 32'(wdt[1]), 32'd0);
    wait_until(c0 + 1010);
    check("wdt_after_timeout", 32'(wdt[1]), 32'd1);
    check("wdt_oe_n", 32'(oe_n[1]), 32'd1);
    issue(1, 16'h0001, c1);
    push_xfer(1, 16'b1000_0000_0000_0000, c1 + 33, c1 + 34);
    wait_until(c1 + 40);
    check("wdt_xfer_oe_n", 32'(oe_n[1]), 32'd1);
    check("wdt_sticky", 32'(wdt[1]), 32'd1);
    check_drained(1, "wdt");
    RST = 1'b1;
    #1;
    check("wdt_cleared_by_rst", 32'(wdt[1]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
`else
    repeat (1100) @(negedge CLK);
    check("no_wdt_fault0", 32'(wdt[0]), 32'd0);
    check("no_wdt_fault1", 32'(wdt[1]), 32'd0);
    check("no_wdt_oe_n1", 32'(oe_n[1]), 32'd0);
`endif

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
